// File: rtl/slc3_pkg.sv
// ============================================================================
// Module : slc3_pkg
// Brief  : Shared LC-3 control types: states, opcodes, mux/ALU encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package slc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED      = 5'd0,
    S_FETCH1      = 5'd1,
    S_FETCH2      = 5'd2,
    S_FETCH3      = 5'd3,
    S_DECODE      = 5'd4,
    S_ADD         = 5'd5,
    S_AND         = 5'd6,
    S_NOT         = 5'd7,
    S_BR          = 5'd8,
    S_BR_TAKEN    = 5'd9,
    S_JMP         = 5'd10,
    S_JSR1        = 5'd11,
    S_JSR2        = 5'd12,
    S_LDR1        = 5'd13,
    S_LDR2        = 5'd14,
    S_LDR3        = 5'd15,
    S_STR1        = 5'd16,
    S_STR2        = 5'd17,
    S_STR3        = 5'd18,
    S_PAUSE1      = 5'd19,
    S_PAUSE1_HOLD = 5'd20,
    S_PAUSE2      = 5'd21
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_BUS   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b01;
  localparam logic [1:0] PCMUX_INC   = 2'b10;

  localparam logic [1:0] ADDR2_OFF11 = 2'b00;
  localparam logic [1:0] ADDR2_OFF9  = 2'b01;
  localparam logic [1:0] ADDR2_OFF6  = 2'b10;
  localparam logic [1:0] ADDR2_ZERO  = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic [1:0] addr2mux;
    logic       addr1mux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2mux;
    logic [1:0] aluk;
    logic       mem_oe;
    logic       mem_we;
  } ctrl_t;

  // States that drive an SRAM strobe and therefore run the wait counter.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/slc3_wait_cnt.sv
// ============================================================================
// Module : slc3_wait_cnt
// Brief  : Counts 0..MEM_WAIT while a memory strobe is held; done on last.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module slc3_wait_cnt #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic done
);

  generate
    if (MEM_WAIT == 0) begin : g_single_cycle
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, en, clr};
      assign done = 1'b1;
    end else begin : g_counter
      localparam int CW = $clog2(MEM_WAIT + 1);
      logic [CW-1:0] count;

      assign done = (count == CW'(MEM_WAIT));

      always_ff @(posedge clk) begin
        if (reset || clr) begin
          count <= '0;
        end else if (en && !done) begin
          count <= count + CW'(1);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/slc3_control.sv
// ============================================================================
// Module : slc3_control
// Brief  : Moore control FSM for the SLC-3 datapath with SRAM wait states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module slc3_control
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        LD_PC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic [1:0]  ADDR2MUX,
  output logic        ADDR1MUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        SR2MUX,
  output logic [1:0]  ALUK,
  output logic        Mem_OE,
  output logic        Mem_WE
);

  state_t state;
  ctrl_t  ctrl;
  logic   mem_en;
  logic   mem_clr;
  logic   mem_done;
  logic   unused_ir;

  assign unused_ir = ^{IR[10:6], IR[4:0]};

  assign mem_en  = is_mem_state(state);
  assign mem_clr = mem_en & mem_done;

  slc3_wait_cnt #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (mem_en),
    .clr   (mem_clr),
    .done  (mem_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_HALTED;
    end else begin
      case (state)
        S_HALTED:   if (Run) state <= S_FETCH1;
        S_FETCH1:   state <= S_FETCH2;
        S_FETCH2:   if (mem_done) state <= S_FETCH3;
        S_FETCH3:   state <= S_DECODE;
        S_DECODE: begin
          case (IR[15:12])
            OP_ADD:   state <= S_ADD;
            OP_AND:   state <= S_AND;
            OP_NOT:   state <= S_NOT;
            OP_BR:    state <= S_BR;
            OP_JMP:   state <= S_JMP;
            OP_JSR:   state <= S_JSR1;
            OP_LDR:   state <= S_LDR1;
            OP_STR:   state <= S_STR1;
            OP_PAUSE: state <= S_PAUSE1;
            default:  state <= S_FETCH1;
          endcase
        end
        S_BR:       state <= BEN ? S_BR_TAKEN : S_FETCH1;
        S_JSR1:     state <= S_JSR2;
        S_LDR1:     state <= S_LDR2;
        S_LDR2:     if (mem_done) state <= S_LDR3;
        S_STR1:     state <= S_STR2;
        S_STR2:     state <= S_STR3;
        S_STR3:     if (mem_done) state <= S_FETCH1;
        // LD_LED belongs to the entry cycle only; the hold state waits silently.
        S_PAUSE1, S_PAUSE1_HOLD:
                    state <= Continue ? S_PAUSE2 : S_PAUSE1_HOLD;
        S_PAUSE2:   if (!Continue) state <= S_FETCH1;
        default:    state <= S_FETCH1;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH1: begin
        ctrl.gate_pc = 1'b1;
        ctrl.ld_mar  = 1'b1;
        ctrl.pcmux   = PCMUX_INC;
        ctrl.ld_pc   = 1'b1;
      end
      S_FETCH2, S_LDR2: begin
        ctrl.mem_oe = 1'b1;
        ctrl.ld_mdr = mem_done;
      end
      S_FETCH3: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.ld_ir    = 1'b1;
      end
      S_DECODE:   ctrl.ld_ben = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        ctrl.sr1mux   = 1'b1;
        ctrl.sr2mux   = IR[5];
        ctrl.aluk     = (state == S_ADD) ? ALUK_ADD :
                        (state == S_AND) ? ALUK_AND : ALUK_NOT;
        ctrl.gate_alu = 1'b1;
        ctrl.drmux    = 1'b1;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
      end
      S_BR_TAKEN: begin
        ctrl.addr2mux = ADDR2_OFF9;
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.ld_pc    = 1'b1;
      end
      S_JMP: begin
        ctrl.addr1mux = 1'b1;
        ctrl.sr1mux   = 1'b1;
        ctrl.addr2mux = ADDR2_ZERO;
        ctrl.pcmux    = PCMUX_ADDER;
        ctrl.ld_pc    = 1'b1;
      end
      S_JSR1: begin
        ctrl.gate_pc = 1'b1;
        ctrl.ld_reg  = 1'b1;
      end
      S_JSR2: begin
        ctrl.pcmux = PCMUX_ADDER;
        ctrl.ld_pc = 1'b1;
        // IR[11] picks JSR (PC + offset11) versus JSRR (base register).
        if (!IR[11]) begin
          ctrl.addr1mux = 1'b1;
          ctrl.sr1mux   = 1'b1;
          ctrl.addr2mux = ADDR2_ZERO;
        end
      end
      S_LDR1, S_STR1: begin
        ctrl.addr1mux    = 1'b1;
        ctrl.sr1mux      = 1'b1;
        ctrl.addr2mux    = ADDR2_OFF6;
        ctrl.gate_marmux = 1'b1;
        ctrl.ld_mar      = 1'b1;
      end
      S_LDR3: begin
        ctrl.gate_mdr = 1'b1;
        ctrl.drmux    = 1'b1;
        ctrl.ld_reg   = 1'b1;
        ctrl.ld_cc    = 1'b1;
      end
      S_STR2: begin
        ctrl.aluk     = ALUK_PASSA;
        ctrl.gate_alu = 1'b1;
        ctrl.ld_mdr   = 1'b1;
      end
      S_STR3:     ctrl.mem_we = 1'b1;
      S_PAUSE1:   ctrl.ld_led = 1'b1;
      default:    ctrl = '0;
    endcase
  end

  assign LD_MAR     = ctrl.ld_mar;
  assign LD_MDR     = ctrl.ld_mdr;
  assign LD_IR      = ctrl.ld_ir;
  assign LD_BEN     = ctrl.ld_ben;
  assign LD_CC      = ctrl.ld_cc;
  assign LD_REG     = ctrl.ld_reg;
  assign LD_PC      = ctrl.ld_pc;
  assign LD_LED     = ctrl.ld_led;
  assign GatePC     = ctrl.gate_pc;
  assign GateMDR    = ctrl.gate_mdr;
  assign GateALU    = ctrl.gate_alu;
  assign GateMARMUX = ctrl.gate_marmux;
  assign PCMUX      = ctrl.pcmux;
  assign ADDR2MUX   = ctrl.addr2mux;
  assign ADDR1MUX   = ctrl.addr1mux;
  assign DRMUX      = ctrl.drmux;
  assign SR1MUX     = ctrl.sr1mux;
  assign SR2MUX     = ctrl.sr2mux;
  assign ALUK       = ctrl.aluk;
  assign Mem_OE     = ctrl.mem_oe;
  assign Mem_WE     = ctrl.mem_we;

endmodule

`default_nettype wire
